fir_mac_sequencer: RTL and testbench

//  Control FSM for a time-multiplexed, symmetric, odd-length FIR datapath.
//  The datapath is one pre-adder, one multiplier and one accumulator, fed by a

---
 rtl/fir_mac_sequencer_if.sv | 31 +++
 rtl/fir_mac_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Control bus between the FIR MAC sequencer and its sample RAM, coefficient ROM
// and accumulator datapath. The sequencer drives through the master modport.
interface fir_mac_sequencer_if #(
  parameter int AW = 7,
  parameter int CW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_zero;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          rd_b_en;
  logic [CW-1:0] coef_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_valid;

  modport master (
    input  in_valid,
    output in_ready, wr_en, wr_addr, wr_zero, rd_addr_a, rd_addr_b,
           rd_b_en, coef_addr, acc_clr, acc_en, out_valid
  );

  modport slave (
    output in_valid,
    input  in_ready, wr_en, wr_addr, wr_zero, rd_addr_a, rd_addr_b,
           rd_b_en, coef_addr, acc_clr, acc_en, out_valid
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a time-multiplexed symmetric odd-length FIR: one sample write,
// HALF pre-add/MAC cycles, then a PIPE-delayed accumulator finish per input sample.
module fir_mac_sequencer #(
  parameter int NTAPS = 127,
  parameter int PIPE  = 2
) (
  input  logic                clk,
  input  logic                rst,
  fir_mac_sequencer_if.master bus
);
  localparam int HALF = (NTAPS + 1) / 2;
  localparam int AW   = $clog2(NTAPS);
  localparam int CW   = $clog2(HALF);
  localparam int CNTW = $clog2(NTAPS + PIPE + 2);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WRITE, ST_MAC, ST_DRAIN, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   newest_q, newest_d;

  logic            in_ready_q, in_ready_d;
  logic            wr_en_q, wr_en_d;
  logic            wr_zero_q, wr_zero_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic            rd_b_en_q, rd_b_en_d;
  logic [CW-1:0]   coef_addr_q, coef_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [PIPE:0]   clr_pipe_q, clr_pipe_d;
  logic [PIPE:0]   en_pipe_q, en_pipe_d;

  logic [AW:0]     k_ext;
  logic [AW:0]     diff;
  logic [AW:0]     sum;
  logic            is_mac;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    newest_d = newest_q;

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == CNTW'(NTAPS)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d  = ST_WRITE;
          newest_d = head_q;
          head_d   = (head_q == AW'(NTAPS - 1)) ? '0 : head_q + 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_MAC;
        cnt_d   = '0;
      end
      ST_MAC: begin
        if (cnt_q == CNTW'(HALF - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNTW'(PIPE - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so that each registered output
    // lands in the same cycle the FSM occupies that phase.
    k_ext = (AW + 1)'(cnt_d);
    diff  = {1'b0, newest_d} - k_ext;
    if (diff[AW]) begin
      diff = diff + (AW + 1)'(NTAPS);
    end
    sum = {1'b0, newest_d} + k_ext + (AW + 1)'(1);
    if (sum >= (AW + 1)'(NTAPS)) begin
      sum = sum - (AW + 1)'(NTAPS);
    end

    is_mac      = (state_d == ST_MAC);
    in_ready_d  = (state_d == ST_IDLE);
    wr_zero_d   = (state_d == ST_INIT) && (cnt_d != '0);
    wr_en_d     = wr_zero_d || (state_d == ST_WRITE);
    wr_addr_d   = '0;
    if (wr_zero_d) begin
      wr_addr_d = AW'(cnt_d - 1'b1);
    end else if (state_d == ST_WRITE) begin
      wr_addr_d = head_q;
    end
    coef_addr_d = is_mac ? CW'(cnt_d) : '0;
    rd_addr_a_d = is_mac ? AW'(diff) : '0;
    rd_addr_b_d = is_mac ? AW'(sum) : '0;
    // Centre tap has a == b; suppress port B so it is not counted twice.
    rd_b_en_d   = is_mac && (cnt_d != CNTW'(HALF - 1));
    clr_pipe_d  = {clr_pipe_q[PIPE-1:0], is_mac && (cnt_d == '0)};
    en_pipe_d   = {en_pipe_q[PIPE-1:0], is_mac && (cnt_d != '0)};
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      head_q      <= '0;
      newest_q    <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_zero_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rd_b_en_q   <= 1'b0;
      coef_addr_q <= '0;
      out_valid_q <= 1'b0;
      clr_pipe_q  <= '0;
      en_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      newest_q    <= newest_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_zero_q   <= wr_zero_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rd_b_en_q   <= rd_b_en_d;
      coef_addr_q <= coef_addr_d;
      out_valid_q <= out_valid_d;
      clr_pipe_q  <= clr_pipe_d;
      en_pipe_q   <= en_pipe_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_zero   = wr_zero_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.rd_b_en   = rd_b_en_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.acc_clr   = clr_pipe_q[PIPE];
  assign bus.acc_en    = en_pipe_q[PIPE];
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a behavioural RAM/ROM/MAC datapath driven by the
// sequencer, checked against a direct-form FIR convolution of the sample history.
module tb_fir_mac_sequencer;
  localparam int NTAPS = 127;
  localparam int PIPE  = 2;
  localparam int HALF  = (NTAPS + 1) / 2;
  localparam int AW    = $clog2(NTAPS);
  localparam int CW    = $clog2(HALF);
  localparam int PERIOD = HALF + PIPE + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.AW(AW), .CW(CW)) bus ();
  fir_mac_sequencer_if #(.AW(AW), .CW(CW)) bus2 ();

  fir_mac_sequencer #(.NTAPS(NTAPS), .PIPE(PIPE)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  fir_mac_sequencer #(.NTAPS(NTAPS), .PIPE(4))    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int exp_head = 0;
  int last_accept = 0;
  longint in_data = 0;
  longint hist[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint coef(input int k);
    return longint'((k * 37 + 11) % 201) - 100;
  endfunction

  // Direct-form reference: y = sum_i h[i] * x[n-i], h symmetric about the centre.
  function automatic longint ref_y();
    longint y = 0;
    for (int i = 0; i < NTAPS; i++) begin
      if (i < hist.size())
        y += coef((i < HALF) ? i : NTAPS - 1 - i) * hist[i];
    end
    return y;
  endfunction

  // Behavioural datapath: RAM, ROM, pre-adder, PIPE-deep product delay, accumulator.
  longint ram [NTAPS];
  longint prod_pipe [PIPE];
  longint lat_q = 0;
  longint acc_m = 0;
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) lat_q <= in_data;
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_zero ? 64'sd0 : lat_q;
    prod_pipe[0] <= coef(int'(bus.coef_addr)) *
                    (ram[bus.rd_addr_a] + (bus.rd_b_en ? ram[bus.rd_addr_b] : 64'sd0));
    for (int j = 1; j < PIPE; j++) prod_pipe[j] <= prod_pipe[j-1];
    if (bus.acc_clr)     acc_m <= prod_pipe[PIPE-1];
    else if (bus.acc_en) acc_m <= acc_m + prod_pipe[PIPE-1];
  end

  task automatic do_reset(input bit both);
    logic [AW+5:0] got, exp;
    @(negedge clk);
    rst = 1'b1;
    if (both) rst2 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    hist.delete();
    exp_head = 0;
    got = {bus.wr_en, bus.wr_zero, bus.wr_addr, bus.in_ready, bus.out_valid, bus.acc_en, bus.acc_clr};
    total_cnt++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else pass_cnt++;
    for (int i = 0; i < NTAPS; i++) begin
      @(negedge clk);
      got = {bus.wr_en, bus.wr_zero, bus.wr_addr, bus.in_ready, bus.out_valid, bus.acc_en, bus.acc_clr};
      exp = {1'b1, 1'b1, AW'(i), 4'b0000};
      total_cnt++;
      if (got !== exp) $display("FAIL init_sweep[%0d]: got %h expected %h", i, got, exp);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({bus.in_ready, bus.wr_en} !== 2'b10)
      $display("FAIL init_done_ready: got %b expected 10", {bus.in_ready, bus.wr_en});
    else pass_cnt++;
    $display("reset: init sweep of %0d addresses observed", NTAPS);
  endtask

  // Presents one sample and checks every cycle of its processing window.
  task automatic run_sample(input longint data, input bit hold, input int exp_gap);
    int waitn = 0;
    int a_cyc, newest, k, ea, eb;
    longint y_exp;
    logic [2*AW+CW+1:0] got_m, exp_m;
    logic [3:0] got_c, exp_c;
    in_data = data;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waitn < 300) begin
      @(negedge clk);
      waitn++;
    end
    total_cnt++;
    if (!bus.in_ready) begin
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    pass_cnt++;
    a_cyc = cyc;
    if (exp_gap > 0) begin
      total_cnt++;
      if (a_cyc - last_accept !== exp_gap)
        $display("FAIL accept_gap: got %0d expected %0d", a_cyc - last_accept, exp_gap);
      else pass_cnt++;
    end
    last_accept = a_cyc;
    hist.push_front(data);
    y_exp = ref_y();
    newest = exp_head;
    exp_head = (exp_head + 1) % NTAPS;
    for (int off = 1; off <= PERIOD; off++) begin
      @(negedge clk);
      if (off == 1 && !hold) bus.in_valid = 1'b0;
      if (off == 1) begin
        total_cnt++;
        if ({bus.wr_en, bus.wr_zero, bus.wr_addr} !== {1'b1, 1'b0, AW'(newest)})
          $display("FAIL write: got en=%b zero=%b addr=%0d expected en=1 zero=0 addr=%0d",
                   bus.wr_en, bus.wr_zero, bus.wr_addr, newest);
        else pass_cnt++;
      end else if (off <= HALF + 1) begin
        k = off - 2;
        ea = (newest - k + NTAPS) % NTAPS;
        eb = (newest + 1 + k) % NTAPS;
        got_m = {bus.wr_en, bus.coef_addr, bus.rd_addr_a, bus.rd_addr_b, bus.rd_b_en};
        exp_m = {1'b0, CW'(k), AW'(ea), AW'(eb), k != HALF - 1};
        total_cnt++;
        if (got_m !== exp_m) $display("FAIL mac_addr k=%0d: got %h expected %h", k, got_m, exp_m);
        else pass_cnt++;
      end
      got_c = {bus.acc_clr, bus.acc_en, bus.out_valid, bus.in_ready};
      exp_c = {off == 2 + PIPE, (off >= 3 + PIPE) && (off <= 1 + HALF + PIPE),
               off == HALF + PIPE + 2, off == PERIOD};
      total_cnt++;
      if (got_c !== exp_c) $display("FAIL ctrl off=%0d: got %b expected %b", off, got_c, exp_c);
      else pass_cnt++;
      if (off == HALF + PIPE + 2) begin
        total_cnt++;
        if (acc_m !== y_exp) $display("FAIL fir_output: got %0d expected %0d", acc_m, y_exp);
        else pass_cnt++;
      end
    end
    $display("sample: accept@%0d data=%0d addr=%0d y=%0d", a_cyc, data, newest, y_exp);
  endtask

  function automatic longint rand_sample();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_single_samples();
    run_sample(rand_sample(), 1'b0, 0);
    run_sample(rand_sample(), 1'b0, PERIOD);
    run_sample(rand_sample(), 1'b0, PERIOD);
  endtask

  // Held in_valid: accepts must be exactly PERIOD apart; long enough to wrap head.
  task automatic test_back_to_back();
    for (int i = 0; i < 130; i++) run_sample(rand_sample(), 1'b1, (i == 0) ? 0 : PERIOD);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_pipe4();
    int waitn = 0, first_clr = -1, last_en = -1, ov_at = -1, ov_cnt = 0, both = 0;
    bus2.in_valid = 1'b1;
    while (!bus2.in_ready && waitn < 300) begin
      @(negedge clk);
      waitn++;
    end
    for (int off = 1; off <= 75; off++) begin
      @(negedge clk);
      if (off == 1) bus2.in_valid = 1'b0;
      if (bus2.acc_clr && first_clr < 0) first_clr = off;
      if (bus2.acc_en) last_en = off;
      if (bus2.acc_en && bus2.acc_clr) both++;
      if (bus2.out_valid) begin
        ov_at = off;
        ov_cnt++;
      end
    end
    total_cnt++;
    if ({first_clr, last_en, ov_at, ov_cnt, both} !== {32'd6, 32'd69, 32'd70, 32'd1, 32'd0})
      $display("FAIL pipe4_timing: got clr=%0d en_last=%0d ov=%0d n_ov=%0d both=%0d expected 6 69 70 1 0",
               first_clr, last_en, ov_at, ov_cnt, both);
    else pass_cnt++;
    $display("pipe4: acc_clr@A+%0d last acc_en@A+%0d out_valid@A+%0d", first_clr, last_en, ov_at);
  endtask

  task automatic test_reset_mid();
    int waitn = 0;
    bus.in_valid = 1'b1;
    in_data = rand_sample();
    while (!bus.in_ready && waitn < 300) begin
      @(negedge clk);
      waitn++;
    end
    for (int off = 1; off <= 29; off++) begin
      @(negedge clk);
      if (off == 1) bus.in_valid = 1'b0;
    end
    total_cnt++;
    if (bus.acc_en !== 1'b1) $display("FAIL mid_acc_en: got %b expected 1", bus.acc_en);
    else pass_cnt++;
    $display("reset_mid: asserting rst at A+30");
    do_reset(1'b0);
    run_sample(rand_sample(), 1'b0, 0);
    run_sample(rand_sample(), 1'b0, PERIOD);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    test_reset();
    test_pipe4();
    test_single_samples();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
